// File: rtl/metronome_prog_if.sv
// Configuration, serial-strobe and status bundle for metronome_prog.
interface metronome_prog_if #(
    parameter int MAX_BITWIDTH = 16,
    parameter int MAX_PASSES   = 256
);
    localparam int CW = $clog2(2 * MAX_BITWIDTH) + 2;
    localparam int BW = $clog2(MAX_BITWIDTH + 1);
    localparam int PW = $clog2(MAX_PASSES + 1);

    logic          cfg_load;
    logic [BW-1:0] cfg_bitwidth;
    logic          cfg_signed;
    logic [PW-1:0] cfg_passes;
    logic          abort;
    logic          device_data_in_valid;
    logic          data_in_valid;
    logic          data_out_valid;
    logic [CW-1:0] last_count;
    logic [PW-1:0] pass_idx;
    logic          busy;
    logic          pass_done;
    logic          cfg_err;

    modport master (
        output cfg_load, cfg_bitwidth, cfg_signed, cfg_passes, abort, device_data_in_valid,
        input  data_in_valid, data_out_valid, last_count, pass_idx, busy, pass_done, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_bitwidth, cfg_signed, cfg_passes, abort, device_data_in_valid,
        output data_in_valid, data_out_valid, last_count, pass_idx, busy, pass_done, cfg_err
    );
endinterface

// File: rtl/metronome_prog.sv
// Programmable bit-period metronome: counts serial-bit strobes through
// periods of bw or 2*bw bits for a configured number of passes.
module metronome_prog #(
    parameter int MAX_BITWIDTH = 16,
    parameter int MAX_PASSES   = 256
) (
    input logic               fast_clk,
    input logic               rst,
    metronome_prog_if.slave   bus
);
    localparam int CW = $clog2(2 * MAX_BITWIDTH) + 2;
    localparam int BW = $clog2(MAX_BITWIDTH + 1);
    localparam int PW = $clog2(MAX_PASSES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_pass;
    logic [PW-1:0] r_n;
    logic [BW-1:0] r_bw;
    logic          r_signed;
    logic          r_cfg_err;

    logic          w_cfg_ok;
    logic [CW-1:0] w_period;
    logic          w_wrap;
    logic [PW-1:0] w_pass_next;
    logic          w_run_valid;

    assign w_cfg_ok = (bus.cfg_bitwidth != '0) && (bus.cfg_bitwidth <= BW'(MAX_BITWIDTH))
                   && (bus.cfg_passes != '0) && (bus.cfg_passes <= PW'(MAX_PASSES));

    // Period derives only from latched configuration, never from live cfg inputs.
    assign w_period    = r_signed ? CW'({r_bw, 1'b0}) : CW'(r_bw);
    assign w_wrap      = (r_count == w_period - CW'(1));
    assign w_pass_next = r_pass + PW'(1);
    assign w_run_valid = (r_state == S_RUN) && bus.device_data_in_valid;

    always_ff @(posedge fast_clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pass    <= '0;
            r_n       <= PW'(1);
            r_bw      <= BW'(1);
            r_signed  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_load) begin
                        if (w_cfg_ok) begin
                            r_bw     <= bus.cfg_bitwidth;
                            r_signed <= bus.cfg_signed;
                            r_n      <= bus.cfg_passes;
                            r_count  <= '0;
                            r_pass   <= '0;
                            r_state  <= S_RUN;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Abort wins over a coincident final wrap.
                    if (bus.abort) begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end else if (bus.device_data_in_valid) begin
                        if (w_wrap) begin
                            r_count <= '0;
                            r_pass  <= w_pass_next;
                            if (w_pass_next == r_n) begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_in_valid  = w_run_valid && (r_count == '0);
    assign bus.data_out_valid = w_run_valid && w_wrap;
    assign bus.last_count     = r_count;
    assign bus.pass_idx       = r_pass;
    assign bus.busy           = (r_state == S_RUN);
    assign bus.pass_done      = (r_state == S_DONE);
    assign bus.cfg_err        = r_cfg_err;
endmodule

// File: tb/tb_metronome_prog.sv
// Directed bench for metronome_prog with a cycle model feeding an expectation queue.
module tb_metronome_prog;
    localparam int MAXB = 8;
    localparam int MAXP = 256;
    localparam int BW   = $clog2(MAXB + 1);
    localparam int PW   = $clog2(MAXP + 1);

    typedef struct {
        logic [31:0] div, dov, lc, pi, busy, pd, err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t scb[$];

    int m_st, m_cnt, m_pass, m_bw, m_sgn, m_n, m_err;
    logic g_div, g_dov, g_pd;

    metronome_prog_if #(.MAX_BITWIDTH(MAXB), .MAX_PASSES(MAXP)) bus ();

    metronome_prog #(.MAX_BITWIDTH(MAXB), .MAX_PASSES(MAXP)) dut (
        .fast_clk (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_st = 0; m_cnt = 0; m_pass = 0; m_bw = 1; m_sgn = 0; m_n = 1; m_err = 0;
    endtask

    task automatic m_update(input logic ld, input int bw, input logic sg, input int n,
                            input logic ab, input logic v);
        int p;
        p = m_sgn ? 2 * m_bw : m_bw;
        m_err = 0;
        case (m_st)
            0: if (ld) begin
                if (bw >= 1 && bw <= MAXB && n >= 1 && n <= MAXP) begin
                    m_bw = bw; m_sgn = sg; m_n = n; m_cnt = 0; m_pass = 0; m_st = 1;
                end else m_err = 1;
            end
            1: if (ab) begin
                m_cnt = 0; m_st = 0;
            end else if (v) begin
                if (m_cnt == p - 1) begin
                    m_cnt = 0; m_pass++;
                    if (m_pass == m_n) m_st = 2;
                end else m_cnt++;
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic step(input logic ld, input int bw, input logic sg, input int n,
                        input logic ab, input logic v);
        exp_t e;
        exp_t o;
        int p;
        @(negedge clk);
        bus.cfg_load = ld;
        bus.cfg_bitwidth = BW'(bw);
        bus.cfg_signed = sg;
        bus.cfg_passes = PW'(n);
        bus.abort = ab;
        bus.device_data_in_valid = v;
        p = m_sgn ? 2 * m_bw : m_bw;
        e.busy = 32'(m_st == 1);
        e.div  = 32'(m_st == 1 && v && m_cnt == 0);
        e.dov  = 32'(m_st == 1 && v && m_cnt == p - 1);
        e.lc   = m_cnt;
        e.pi   = m_pass;
        e.pd   = 32'(m_st == 2);
        e.err  = m_err;
        scb.push_back(e);
        #1;
        o = scb.pop_front();
        check("data_in_valid",  32'(bus.data_in_valid),  o.div);
        check("data_out_valid", 32'(bus.data_out_valid), o.dov);
        check("last_count",     32'(bus.last_count),     o.lc);
        check("pass_idx",       32'(bus.pass_idx),       o.pi);
        check("busy",           32'(bus.busy),           o.busy);
        check("pass_done",      32'(bus.pass_done),      o.pd);
        check("cfg_err",        32'(bus.cfg_err),        o.err);
        g_div = bus.data_in_valid;
        g_dov = bus.data_out_valid;
        g_pd  = bus.pass_done;
        m_update(ld, bw, sg, n, ab, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int ndiv, ndov, pd_step;
        bus.cfg_load = 1'b0; bus.cfg_bitwidth = '0; bus.cfg_signed = 1'b0;
        bus.cfg_passes = '0; bus.abort = 1'b0; bus.device_data_in_valid = 1'b0;
        m_reset();

        #1 rst = 1'b0;
        #2;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_count", 32'(bus.last_count), 0);
        check("rst_pass", 32'(bus.pass_idx), 0);
        #4 rst = 1'b1;

        step(0, 0, 0, 0, 1, 1);            // idle: abort and valid ignored

        // bw=8 signed, two passes, valid held high
        step(1, 8, 1, 2, 0, 0);
        ndiv = 0; ndov = 0; pd_step = -1;
        for (int k = 1; k <= 34; k++) begin
            step(0, 0, 0, 0, 0, 1);
            if (g_div) ndiv++;
            if (g_dov) ndov++;
            if (g_pd && pd_step < 0) pd_step = k;
        end
        check("s36_pd_step", pd_step, 33);
        check("s36_ndiv", ndiv, 2);
        check("s36_ndov", ndov, 2);

        // bw=4 unsigned, one pass, valid toggling
        step(1, 4, 0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) step(0, 0, 0, 0, 0, (k % 2) == 1);

        // rejected configurations, then an accepted one
        step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 9, 0, 1, 0, 0);
        step(1, 3, 0, 0, 0, 0);
        step(1, 3, 0, 257, 0, 0);
        step(1, 3, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1);

        // abort on the final wrap
        step(1, 2, 0, 2, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);

        // cfg_load ignored in RUN, then async reset at count 5
        step(1, 8, 0, 2, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1);
        step(1, 2, 1, 3, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        bus.cfg_load = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 0);
        check("arst_count", 32'(bus.last_count), 0);
        check("arst_pass", 32'(bus.pass_idx), 0);
        check("arst_pd", 32'(bus.pass_done), 0);
        check("arst_err", 32'(bus.cfg_err), 0);
        m_reset();
        #1 rst = 1'b1;
        step(1, 2, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1);

        // bw=1 unsigned, maximum passes
        step(1, 1, 0, MAXP, 0, 0);
        for (int k = 0; k < MAXP + 2; k++) step(0, 0, 0, 0, 0, 1);
        check("max_pass_idx", 32'(bus.pass_idx), MAXP);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/metronome_prog.md
METRONOME_PROG -- requirements
Module: metronome_prog

Interface
REQ-001 Parameter MAX_BITWIDTH, default 16, SHALL set the largest operand width supported.
REQ-002 Parameter MAX_PASSES, default 256, SHALL set the largest number of periods per job.
REQ-003 Derived widths SHALL be CW = clog2(2*MAX_BITWIDTH)+2, BW = clog2(MAX_BITWIDTH+1), PW = clog2(MAX_PASSES+1).
REQ-004 fast_clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-005 rst, input, 1: reset; SHALL be asynchronous and active-low.
REQ-006 cfg_load, input, 1: one-cycle request to latch configuration and start a job.
REQ-007 cfg_bitwidth, input, BW: operand width bw for the job.
REQ-008 cfg_signed, input, 1: 1 SHALL select period 2*bw; 0 SHALL select period bw.
REQ-009 cfg_passes, input, PW: number of periods N in the job.
REQ-010 abort, input, 1: terminates the current job.
REQ-011 device_data_in_valid, input, 1: serial-bit strobe; the counter advances only when high.
REQ-012 data_in_valid, output, 1: marks the first bit of a period.
REQ-013 data_out_valid, output, 1: marks the last bit of a period.
REQ-014 last_count, output, CW: current bit index within the period.
REQ-015 pass_idx, output, PW: number of completed periods in the current job.
REQ-016 busy, output, 1: high in RUN.
REQ-017 pass_done, output, 1: one-cycle job-completion pulse.
REQ-018 cfg_err, output, 1: one-cycle pulse flagging a rejected configuration.

Function
REQ-019 The state machine SHALL have three states: IDLE, RUN and DONE.
REQ-020 IDLE: if cfg_load=1 and 1<=cfg_bitwidth<=MAX_BITWIDTH and 1<=cfg_passes<=MAX_PASSES, the block SHALL latch bw, signed and N, clear count and pass_idx, and go to RUN next cycle.
REQ-021 IDLE: a cfg_load with bitwidth or passes out of range SHALL pulse cfg_err for one cycle; the block SHALL stay in IDLE with the previous configuration kept.
REQ-022 RUN: cfg_load SHALL be ignored, with no cfg_err.
REQ-023 Period P SHALL be 2*bw if signed, else bw; P is computed from latched values only.
REQ-024 RUN with device_data_in_valid=1: count SHALL increment, wrapping from P-1 to 0; each wrap SHALL increment pass_idx.
REQ-025 RUN with device_data_in_valid=0: count and pass_idx SHALL hold (stall).
REQ-026 data_in_valid SHALL be combinational: busy AND device_data_in_valid AND (count==0).
REQ-027 data_out_valid SHALL be combinational: busy AND device_data_in_valid AND (count==P-1).
REQ-028 For bw=1 unsigned (P=1), data_in_valid and data_out_valid SHALL both assert on every valid cycle.
REQ-029 A wrap that takes pass_idx to N SHALL move RUN to DONE; DONE SHALL last exactly one cycle with pass_done=1, then return to IDLE.
REQ-030 In DONE and IDLE, device_data_in_valid SHALL be ignored; data_in_valid and data_out_valid SHALL be 0.
REQ-031 last_count SHALL equal count; pass_idx SHALL hold its final value through IDLE until the next accepted cfg_load.
REQ-032 abort=1 in RUN SHALL force IDLE next cycle and clear count with no pass_done; abort SHALL take priority over a simultaneous final wrap.
REQ-033 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-034 rst=0 SHALL immediately force IDLE and set count=0, pass_idx=0, busy=0, pass_done=0, cfg_err=0, bw=1, signed=0 and N=1, including during RUN.
REQ-035 After rst is released, the first accepted cfg_load SHALL start a job normally.

Verification
REQ-036 MAX_BITWIDTH=8; load bw=8, signed=1, N=2; valid held high -> data_in_valid at counts 0, data_out_valid at counts 15 (twice), pass_done at cycle 33 after load, then IDLE.
REQ-037 bw=4, unsigned, N=1; valid toggling 1,0 -> count holds on 0 cycles; data_out_valid only on valid cycle with count=3; pass_done after 8th cycle.
REQ-038 cfg_load with bw=0, then bw=9 -> cfg_err pulses each time; busy stays 0; next valid load bw=3 is accepted.
REQ-039 abort coincident with count=P-1 of final pass -> no pass_done; IDLE next cycle; last_count=0.
REQ-040 rst asserted mid-RUN at count=5 -> all outputs reset asynchronously; cfg_load during RUN ignored (no cfg_err).
REQ-041 bw=1 unsigned, N=MAX_PASSES -> data_in_valid=data_out_valid=1 every cycle; pass_idx reaches MAX_PASSES without overflow.
